// File: rtl/vrf_wb_arbiter.sv
// Write-back arbiter and busy scoreboard for the 16 x 128-bit vector register file.
// Define VRF_ARB_RR_EN for round-robin arbitration; default is fixed LSU-over-ALU priority.
module vrf_wb_arbiter #(
    parameter int NREG = 16,
    parameter int AW   = 4,
    parameter int DW   = 128
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_addr,
    input  logic [DW-1:0]   alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_addr,
    input  logic [DW-1:0]   lsu_data,
    output logic            wre,
    output logic [AW-1:0]   a3,
    output logic [DW-1:0]   wd3,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_addr,
    input  logic [AW-1:0]   chk_a1,
    input  logic [AW-1:0]   chk_a2,
    input  logic [AW-1:0]   chk_a3,
    output logic            hazard,
    output logic [NREG-1:0] busy,
    output logic            err
);

    logic alu_gnt;
    logic lsu_gnt;

`ifdef VRF_ARB_RR_EN
    typedef enum logic {
        PTR_ALU = 1'b0,
        PTR_LSU = 1'b1
    } ptr_t;

    ptr_t ptr_q;
    ptr_t ptr_d;

    // Contended grants follow the pointer, which then flips to the loser.
    always_comb begin
        alu_gnt = alu_valid & ~lsu_valid;
        lsu_gnt = lsu_valid & ~alu_valid;
        ptr_d   = ptr_q;
        if (alu_valid && lsu_valid) begin
            alu_gnt = (ptr_q == PTR_ALU);
            lsu_gnt = (ptr_q == PTR_LSU);
            ptr_d   = (ptr_q == PTR_ALU) ? PTR_LSU : PTR_ALU;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= PTR_ALU;
        else     ptr_q <= ptr_d;
    end
`else
    // Fixed priority: the load unit always wins.
    always_comb begin
        lsu_gnt = lsu_valid;
        alu_gnt = alu_valid & ~lsu_valid;
    end
`endif

    assign alu_ready = alu_gnt;
    assign lsu_ready = lsu_gnt;

    // Output stage: one entry, drained every cycle by the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            wre <= 1'b0;
            a3  <= '0;
            wd3 <= '0;
        end else begin
            wre <= alu_gnt | lsu_gnt;
            if (lsu_gnt) begin
                a3  <= lsu_addr;
                wd3 <= lsu_data;
            end else if (alu_gnt) begin
                a3  <= alu_addr;
                wd3 <= alu_data;
            end
        end
    end

    logic [NREG-1:0] busy_d;
    logic            same_clr;
    logic            err_set;

    // Next busy map: commit clears, issue sets, set wins on a collision.
    always_comb begin
        busy_d = busy;
        if (wre) busy_d[a3] = 1'b0;
        if (iss_valid) busy_d[iss_addr] = 1'b1;
    end

    // A re-issue to a register whose write commits this edge is legal.
    always_comb begin
        same_clr = wre && (a3 == iss_addr);
        err_set  = (iss_valid && busy[iss_addr] && !same_clr)
                 | (wre && !busy[a3]);
    end

    // Busy bitmap and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
            err  <= 1'b0;
        end else begin
            busy <= busy_d;
            err  <= err | err_set;
        end
    end

    assign hazard = busy[chk_a1] | busy[chk_a2] | busy[chk_a3];

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// Self-checking bench for vrf_wb_arbiter.
// Expected writes are queued at grant time and matched against wre/a3/wd3.
module tb_vrf_wb_arbiter;

    localparam int NREG = 16;
    localparam int AW   = 4;
    localparam int DW   = 128;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            alu_valid = 1'b0;
    logic            alu_ready;
    logic [AW-1:0]   alu_addr = '0;
    logic [DW-1:0]   alu_data = '0;
    logic            lsu_valid = 1'b0;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_addr = '0;
    logic [DW-1:0]   lsu_data = '0;
    logic            wre;
    logic [AW-1:0]   a3;
    logic [DW-1:0]   wd3;
    logic            iss_valid = 1'b0;
    logic [AW-1:0]   iss_addr = '0;
    logic [AW-1:0]   chk_a1 = '0;
    logic [AW-1:0]   chk_a2 = '0;
    logic [AW-1:0]   chk_a3 = '0;
    logic            hazard;
    logic [NREG-1:0] busy;
    logic            err;

    vrf_wb_arbiter #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_addr  (lsu_addr),
        .lsu_data  (lsu_data),
        .wre       (wre),
        .a3        (a3),
        .wd3       (wd3),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .chk_a1    (chk_a1),
        .chk_a2    (chk_a2),
        .chk_a3    (chk_a3),
        .hazard    (hazard),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("wre", {127'd0, wre}, 1);
                chk("a3", {124'd0, a3}, {124'd0, e.a});
                chk("wd3", wd3, e.d);
            end else begin
                chk("wre_idle", {127'd0, wre}, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] r);
        iss_valid = 1'b1;
        iss_addr  = r;
        step();
        iss_valid = 1'b0;
    endtask

    task automatic wb_req(input logic av, input logic [AW-1:0] aa,
                          input logic [DW-1:0] ad, input logic lv,
                          input logic [AW-1:0] la, input logic [DW-1:0] ld,
                          input logic ea, input logic el);
        exp_t x;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        lsu_valid = lv; lsu_addr = la; lsu_data = ld;
        #1;
        chk("alu_ready", {127'd0, alu_ready}, {127'd0, ea});
        chk("lsu_ready", {127'd0, lsu_ready}, {127'd0, el});
        if (ea || el) begin
            x.due = cyc + 1;
            x.a   = el ? la : aa;
            x.d   = el ? ld : ad;
            q.push_back(x);
        end
        step();
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] pa;
        logic [DW-1:0] pb;
        logic          rr;
`ifdef VRF_ARB_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        pa = {16{8'hA5}};
        #1;
        do_reset();
        mon_en = 1'b1;
        chk("rst_wre", {127'd0, wre}, 0);
        chk("rst_a3", {124'd0, a3}, 0);
        chk("rst_wd3", wd3, 0);
        chk("rst_busy", {112'd0, busy}, 0);
        chk("rst_err", {127'd0, err}, 0);

        issue(4'd5);
        chk("busy5_set", {112'd0, busy}, 128'h20);
        wb_req(1'b1, 4'd5, pa, 1'b0, 4'd0, '0, 1'b1, 1'b0);
        chk("busy5_pend", {112'd0, busy}, 128'h20);
        step();
        chk("busy5_clr", {112'd0, busy}, 0);
        chk("err_t1", {127'd0, err}, 0);

        do_reset();
        issue(4'd1);
        issue(4'd2);
        for (int i = 0; i < 4; i++) begin
            pa = {4{32'hA000_0000 + i}};
            pb = {4{32'hB000_0000 + i}};
            wb_req(1'b1, 4'd1, pa, 1'b1, 4'd2, pb,
                   rr & (i % 2 == 0), ~rr | (i % 2 == 1));
        end
        wb_req(1'b0, 4'd0, '0, 1'b1, 4'd11, {8{16'hC0DE}}, 1'b0, 1'b1);
        do_reset();

        issue(4'd3);
        chk_a1 = 4'd3; chk_a2 = 4'd0; chk_a3 = 4'd0;
        #1 chk("haz_a1", {127'd0, hazard}, 1);
        chk_a1 = 4'd4; chk_a2 = 4'd7; chk_a3 = 4'd9;
        #1 chk("haz_none", {127'd0, hazard}, 0);
        chk_a3 = 4'd3;
        #1 chk("haz_a3", {127'd0, hazard}, 1);
        chk_a3 = 4'd9;
        wb_req(1'b1, 4'd3, {4{32'h3333_0003}}, 1'b0, 4'd0, '0, 1'b1, 1'b0);
        step();
        chk_a1 = 4'd3;
        #1 chk("haz_clr", {127'd0, hazard}, 0);
        chk("err_t3", {127'd0, err}, 0);

        issue(4'd6);
        wb_req(1'b0, 4'd0, '0, 1'b1, 4'd6, {4{32'h6666_0006}}, 1'b0, 1'b1);
        issue(4'd6);
        chk("busy6_same", {112'd0, busy}, 128'h40);
        chk("err_same", {127'd0, err}, 0);
        do_reset();

        issue(4'd2);
        issue(4'd2);
        chk("err_dup", {127'd0, err}, 1);
        step();
        step();
        chk("err_sticky", {127'd0, err}, 1);
        do_reset();
        wb_req(1'b0, 4'd0, '0, 1'b1, 4'd8, {4{32'h8888_0008}}, 1'b0, 1'b1);
        step();
        chk("err_nobusy", {127'd0, err}, 1);
        do_reset();
        chk("err_rst", {127'd0, err}, 0);
        chk("busy_rst", {112'd0, busy}, 0);

        issue(4'd10);
        wb_req(1'b1, 4'd10, {4{32'hAAAA_000A}}, 1'b0, 4'd0, '0, 1'b1, 1'b0);
        chk("busy10", {112'd0, busy}, 128'h400);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_wre", {127'd0, wre}, 0);
        chk("rst_mid_busy", {112'd0, busy}, 0);
        step();
        step();
        chk("q_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
